muldiv_seq: RTL

//  Multi-cycle RV32M sequencer that borrows the shared 32-bit alu to compute MUL/MULHU/DIV/DIVU/REM/REMU
//  by iterative shift-add / restoring subtract. Sits beside the execute stage; owns the alu while busy,

---
 rtl/muldiv_pkg.sv | 49 ++++
 rtl/muldiv_seq_if.sv | 28 ++
 rtl/muldiv_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and helpers for the muldiv_seq RV32M sequencer.
//   op_e        funct3 encoding of the M-extension ops
//   state_e     sequencer FSM states
//   ALU_ADD/SUB control codes understood by the shared alu
//   carry_out() / borrow_out() recover bit 32 of an alu add / subtract from
//   the operands and the 32-bit result, since the alu exposes no carry.
package muldiv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ITERS = XLEN;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    typedef enum logic [2:0] {
        OpMul    = 3'b000,
        OpMulh   = 3'b001,
        OpMulhsu = 3'b010,
        OpMulhu  = 3'b011,
        OpDiv    = 3'b100,
        OpDivu   = 3'b101,
        OpRem    = 3'b110,
        OpRemu   = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StNegA,
        StNegB,
        StIter,
        StFix,
        StDone
    } state_e;

    function automatic logic carry_out(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                       input logic [XLEN-1:0] res);
        logic [XLEN-1:0] t;
        t = (a & b) | ((a | b) & ~res);
        return t[XLEN-1];
    endfunction

    function automatic logic borrow_out(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                        input logic [XLEN-1:0] res);
        logic [XLEN-1:0] t;
        t = (~a & b) | (~(a ^ b) & res);
        return t[XLEN-1];
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/response handshake between the execute stage and muldiv_seq.
//   req_valid/req_ready/req_op/req_a/req_b   request channel (op is funct3)
//   resp_valid/resp_ready/resp_data/resp_illegal  response channel
// master = requester (execute stage), slave = muldiv_seq.
interface muldiv_seq_if;
    import muldiv_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic            resp_illegal;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_illegal
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data, resp_illegal
    );

endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M sequencer that borrows the shared alu.
//   clk, rst_n            clock, synchronous active-low reset
//   bus (slave)           request/response handshake (muldiv_seq_if)
//   ex_a, ex_b, ex_ctrl   execute-stage alu operands, passed through when idle/done
//   ex_stall              high while this block owns the alu
//   alu_a, alu_b, alu_ctrl  drive the shared alu
//   alu_res               alu result
// Configuration macro: MULDIV_DIV0_FAST_EN -- when defined, divide/remainder by zero
// completes directly from idle without using the alu.
module muldiv_seq
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    muldiv_seq_if.slave     bus,
    input  logic [XLEN-1:0] ex_a,
    input  logic [XLEN-1:0] ex_b,
    input  logic [3:0]      ex_ctrl,
    output logic            ex_stall,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_res
);

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d;     // product high half / partial remainder
    logic [XLEN-1:0] lo_q, lo_d;     // multiplier -> product low half / dividend -> quotient
    logic [XLEN-1:0] b_q, b_d;       // multiplicand / divisor
    logic            a_neg_q, a_neg_d;
    logic            b_neg_q, b_neg_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            illegal_q, illegal_d;

    logic            is_div, is_rem, signed_div;
    logic [XLEN-1:0] div_shift, mul_addend, fix_x;
    logic            fix_neg, req_illegal, div0_fast;

    assign is_div     = op_q[2];
    assign is_rem     = op_q[2] & op_q[1];
    assign signed_div = op_q[2] & ~op_q[0];
    assign div_shift  = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
    assign mul_addend = lo_q[0] ? b_q : '0;
    assign fix_x      = (op_q == OpMulhu || is_rem) ? hi_q : lo_q;
    // Remainder takes the dividend's sign; quotient is negated on sign mismatch unless /0.
    assign fix_neg    = is_rem ? a_neg_q
                               : (is_div && (a_neg_q ^ b_neg_q) && (b_q != '0));
    assign req_illegal = (bus.req_op == OpMulh) || (bus.req_op == OpMulhsu);

`ifdef MULDIV_DIV0_FAST_EN
    assign div0_fast = bus.req_op[2] && (bus.req_b == '0);
`else
    assign div0_fast = 1'b0;
`endif

    assign bus.req_ready    = (state_q == StIdle);
    assign bus.resp_valid   = (state_q == StDone);
    assign bus.resp_data    = data_q;
    assign bus.resp_illegal = illegal_q;
    assign ex_stall         = (state_q != StIdle) && (state_q != StDone);

    // Alu mux kept apart from next-state logic so alu_res never feeds back into this block.
    always_comb begin
        alu_a    = ex_a;
        alu_b    = ex_b;
        alu_ctrl = ex_ctrl;
        unique case (state_q)
            StNegA: begin alu_a = '0; alu_b = lo_q; alu_ctrl = ALU_SUB; end
            StNegB: begin alu_a = '0; alu_b = b_q;  alu_ctrl = ALU_SUB; end
            StIter: begin
                if (is_div) begin
                    alu_a = div_shift; alu_b = b_q; alu_ctrl = ALU_SUB;
                end else begin
                    alu_a = hi_q; alu_b = mul_addend; alu_ctrl = ALU_ADD;
                end
            end
            StFix:  begin alu_a = '0; alu_b = fix_x; alu_ctrl = ALU_SUB; end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        b_d       = b_q;
        a_neg_d   = a_neg_q;
        b_neg_d   = b_neg_q;
        data_d    = data_q;
        illegal_d = illegal_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    op_d      = op_e'(bus.req_op);
                    lo_d      = bus.req_a;
                    b_d       = bus.req_b;
                    hi_d      = '0;
                    illegal_d = 1'b0;
                    if (req_illegal) begin
                        data_d    = '0;
                        illegal_d = 1'b1;
                        state_d   = StDone;
                    end else if (div0_fast) begin
                        data_d  = bus.req_op[1] ? bus.req_a : '1;
                        state_d = StDone;
                    end else begin
                        state_d = StNegA;
                    end
                end
            end
            StNegA: begin
                a_neg_d = signed_div & lo_q[XLEN-1];
                if (signed_div && lo_q[XLEN-1]) lo_d = alu_res;
                state_d = StNegB;
            end
            StNegB: begin
                b_neg_d = signed_div & b_q[XLEN-1];
                if (signed_div && b_q[XLEN-1]) b_d = alu_res;
                hi_d    = '0;
                cnt_d   = '0;
                state_d = StIter;
            end
            StIter: begin
                cnt_d = cnt_q + 6'd1;
                if (is_div) begin
                    // A set bit shifted out of the remainder means it already exceeds the divisor.
                    if (hi_q[XLEN-1] || !borrow_out(div_shift, b_q, alu_res)) begin
                        hi_d = alu_res;
                        lo_d = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_d = div_shift;
                        lo_d = {lo_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    hi_d = {carry_out(hi_q, mul_addend, alu_res), alu_res[XLEN-1:1]};
                    lo_d = {alu_res[0], lo_q[XLEN-1:1]};
                end
                if (cnt_q == 6'(ITERS - 1)) state_d = StFix;
            end
            StFix: begin
                data_d  = fix_neg ? alu_res : fix_x;
                state_d = StDone;
            end
            StDone: begin
                if (bus.resp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            op_q      <= OpMul;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            data_q    <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            b_q       <= b_d;
            a_neg_q   <= a_neg_d;
            b_neg_q   <= b_neg_d;
            data_q    <= data_d;
            illegal_q <= illegal_d;
        end
    end

endmodule
